// File: rtl/pw_trigger_monitor_pkg.sv
// Shared definitions for the pulse-width trigger monitor: FSM state encoding
// and default counter widths, common with the trigger generator and register map.
package pw_trigger_monitor_pkg;

  localparam int DELAY_WIDTH_DEFAULT = 20;
  localparam int WIDTH_WIDTH_DEFAULT = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    DONE
  } pw_state_t;

endpackage

// File: rtl/pw_sat_counter.sv
// Parameterised saturating up-counter with synchronous load and enable.
// It publishes the value the counter will hold after the coming edge, so the
// owner can latch a result on the same edge the counter advances.
module pw_sat_counter #(
  parameter int WIDTH = 20
) (
  input  logic             trigger_clk,
  input  logic             reset_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count_next,
  output logic             sat_next
);

  logic [WIDTH-1:0] count;

  // Next value: load wins, otherwise count up and stick at all-ones
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_value;
    end else if (enable && (count != '1)) begin
      count_next = count + 1'b1;
    end
    sat_next = &count_next;
  end

  // Counter register with synchronous reset
  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/pw_trigger_monitor.sv
// Pulse-width trigger monitor: measures the delay from a start pulse to the
// trigger's rising edge and the trigger's high width, in trigger_clk cycles,
// and holds the result until acknowledged.
// Optional build macro PW_TRIGMON_TIMEOUT_EN: when defined, a saturated delay
// counter ends the measurement with an all-ones delay and a zero width instead
// of waiting indefinitely for an edge.
module pw_trigger_monitor
  import pw_trigger_monitor_pkg::*;
#(
  parameter int pDELAY_WIDTH = DELAY_WIDTH_DEFAULT,
  parameter int pWIDTH_WIDTH = WIDTH_WIDTH_DEFAULT
) (
  input  logic                    trigger_clk,
  input  logic                    reset_i,
  input  logic                    I_start,
  input  logic                    I_trigger,
  input  logic                    I_ack,
  output logic [pDELAY_WIDTH-1:0] O_delay,
  output logic [pWIDTH_WIDTH-1:0] O_width,
  output logic                    O_valid,
  output logic                    O_delay_ovf,
  output logic                    O_width_ovf,
  output logic                    O_busy
);

  localparam logic [pWIDTH_WIDTH-1:0] WIDTH_ONE = 1;

  pw_state_t state;
  pw_state_t state_next;

  logic trigger_r;
  logic rise;

  logic                    d_load;
  logic                    d_enable;
  logic [pDELAY_WIDTH-1:0] d_count_next;
  logic                    d_sat_next;

  logic                    w_load;
  logic                    w_enable;
  logic [pWIDTH_WIDTH-1:0] w_count_next;
  logic                    w_sat_next;

  logic latch_delay;
  logic latch_width;
  logic clear_flags;
  logic set_dovf;
  logic set_wovf;
`ifdef PW_TRIGMON_TIMEOUT_EN
  logic timeout;
`endif

  assign rise    = I_trigger & ~trigger_r;
  assign O_valid = (state == DONE);
  assign O_busy  = (state == WAIT_EDGE) || (state == MEASURE);

  pw_sat_counter #(
    .WIDTH(pDELAY_WIDTH)
  ) u_delay_counter (
    .trigger_clk(trigger_clk),
    .reset_i    (reset_i),
    .load       (d_load),
    .load_value ('0),
    .enable     (d_enable),
    .count_next (d_count_next),
    .sat_next   (d_sat_next)
  );

  pw_sat_counter #(
    .WIDTH(pWIDTH_WIDTH)
  ) u_width_counter (
    .trigger_clk(trigger_clk),
    .reset_i    (reset_i),
    .load       (w_load),
    .load_value (WIDTH_ONE),
    .enable     (w_enable),
    .count_next (w_count_next),
    .sat_next   (w_sat_next)
  );

  // State register
  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter/latch control; the delay counter also advances on
  // the edge cycle so its next value is exactly start-to-edge distance
  always_comb begin
    state_next  = state;
    d_load      = 1'b0;
    d_enable    = 1'b0;
    w_load      = 1'b0;
    w_enable    = 1'b0;
    latch_delay = 1'b0;
    latch_width = 1'b0;
    clear_flags = 1'b0;
    set_dovf    = 1'b0;
    set_wovf    = 1'b0;
`ifdef PW_TRIGMON_TIMEOUT_EN
    timeout     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (I_start) begin
          d_load      = 1'b1;
          clear_flags = 1'b1;
          state_next  = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        d_enable = 1'b1;
        set_dovf = d_sat_next;
        if (rise) begin
          latch_delay = 1'b1;
          w_load      = 1'b1;
          state_next  = MEASURE;
        end
`ifdef PW_TRIGMON_TIMEOUT_EN
        else if (d_sat_next) begin
          latch_delay = 1'b1;
          timeout     = 1'b1;
          state_next  = DONE;
        end
`endif
      end
      MEASURE: begin
        if (I_trigger) begin
          w_enable = 1'b1;
          set_wovf = w_sat_next;
        end else begin
          latch_width = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (I_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Trigger history, result latches and sticky overflow flags
  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      trigger_r   <= 1'b0;
      O_delay     <= '0;
      O_width     <= '0;
      O_delay_ovf <= 1'b0;
      O_width_ovf <= 1'b0;
    end else begin
      trigger_r <= I_trigger;
      if (latch_delay) begin
        O_delay <= d_count_next;
      end
      if (latch_width) begin
        O_width <= w_count_next;
      end
`ifdef PW_TRIGMON_TIMEOUT_EN
      else if (timeout) begin
        O_width <= '0;
      end
`endif
      if (clear_flags) begin
        O_delay_ovf <= 1'b0;
        O_width_ovf <= 1'b0;
      end else begin
        if (set_dovf) begin
          O_delay_ovf <= 1'b1;
        end
        if (set_wovf) begin
          O_width_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pw_trigger_monitor.sv
// Self-checking bench for pw_trigger_monitor, built with 4-bit counters so
// saturation is reachable in a few cycles. Follows PW_TRIGMON_TIMEOUT_EN.
module tb_pw_trigger_monitor;

  localparam int DW = 4;
  localparam int WW = 4;

  typedef struct {
    bit pre_high;
    int delay;
    int width;
    int exp_delay;
    int exp_width;
    bit exp_dovf;
    bit exp_wovf;
  } vec_t;

  logic          trigger_clk = 1'b0;
  logic          reset_i;
  logic          I_start;
  logic          I_trigger;
  logic          I_ack;
  logic [DW-1:0] O_delay;
  logic [WW-1:0] O_width;
  logic          O_valid;
  logic          O_delay_ovf;
  logic          O_width_ovf;
  logic          O_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  vec_t vectors [7];
  vec_t tmp;

  pw_trigger_monitor #(
    .pDELAY_WIDTH(DW),
    .pWIDTH_WIDTH(WW)
  ) dut (
    .trigger_clk(trigger_clk),
    .reset_i    (reset_i),
    .I_start    (I_start),
    .I_trigger  (I_trigger),
    .I_ack      (I_ack),
    .O_delay    (O_delay),
    .O_width    (O_width),
    .O_valid    (O_valid),
    .O_delay_ovf(O_delay_ovf),
    .O_width_ovf(O_width_ovf),
    .O_busy     (O_busy)
  );

  // Free-running 100 MHz clock
  always #5 trigger_clk = ~trigger_clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task step();
    @(posedge trigger_clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full measurement: start, trigger rises 'delay' cycles later, stays high
  // 'width' cycles, then results are checked and acknowledged
  task applyStimulus(input string tag, input vec_t v);
    checkOutput({tag, "_idle_valid"}, O_valid, 0);
    checkOutput({tag, "_idle_busy"}, O_busy, 0);
    I_start   = 1'b1;
    I_trigger = v.pre_high;
    step();
    I_start = 1'b0;
    checkOutput({tag, "_start_busy"}, O_busy, 1);
    for (int i = 1; i < v.delay; i++) begin
      I_trigger = 1'b0;
      step();
    end
    for (int i = 0; i < v.width; i++) begin
      I_trigger = 1'b1;
      step();
    end
    checkOutput({tag, "_meas_busy"}, O_busy, 1);
    checkOutput({tag, "_meas_valid"}, O_valid, 0);
    I_trigger = 1'b0;
    step();
    checkOutput({tag, "_valid"}, O_valid, 1);
    checkOutput({tag, "_busy_done"}, O_busy, 0);
    checkOutput({tag, "_delay"}, O_delay, v.exp_delay);
    checkOutput({tag, "_width"}, O_width, v.exp_width);
    checkOutput({tag, "_dovf"}, O_delay_ovf, v.exp_dovf);
    checkOutput({tag, "_wovf"}, O_width_ovf, v.exp_wovf);
    I_ack = 1'b1;
    step();
    I_ack = 1'b0;
    checkOutput({tag, "_ack_valid"}, O_valid, 0);
    checkOutput({tag, "_ack_busy"}, O_busy, 0);
    checkOutput({tag, "_ack_delay_held"}, O_delay, v.exp_delay);
    checkOutput({tag, "_ack_width_held"}, O_width, v.exp_width);
  endtask

  initial begin
    // pre_high, delay, width, exp_delay, exp_width, exp_dovf, exp_wovf
    vectors[0] = '{0, 10,  5, 10,  5, 0, 0};
    vectors[1] = '{1,  3,  1,  3,  1, 0, 0};
    vectors[2] = '{0,  1,  1,  1,  1, 0, 0};
    vectors[3] = '{0,  2, 20,  2, 15, 0, 1};
    vectors[4] = '{0, 14, 14, 14, 14, 0, 0};
    vectors[5] = '{0,  4, 15,  4, 15, 0, 1};
    vectors[6] = '{1,  5,  2,  5,  2, 0, 0};

    reset_i   = 1'b1;
    I_start   = 1'b0;
    I_trigger = 1'b0;
    I_ack     = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    checkOutput("rst_delay", O_delay, 0);
    checkOutput("rst_width", O_width, 0);
    checkOutput("rst_valid", O_valid, 0);
    checkOutput("rst_dovf", O_delay_ovf, 0);
    checkOutput("rst_wovf", O_width_ovf, 0);
    checkOutput("rst_busy", O_busy, 0);

    foreach (vectors[i]) begin
      applyStimulus($sformatf("vec%0d", i), vectors[i]);
    end

    // Start pulses in MEASURE and in DONE must not disturb the result
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    step();
    I_trigger = 1'b1;
    step();
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    step();
    I_trigger = 1'b0;
    step();
    checkOutput("restart_valid", O_valid, 1);
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    step();
    step();
    checkOutput("restart_done_valid", O_valid, 1);
    checkOutput("restart_done_busy", O_busy, 0);
    checkOutput("restart_delay", O_delay, 2);
    checkOutput("restart_width", O_width, 3);
    I_ack = 1'b1;
    step();
    I_ack = 1'b0;
    checkOutput("restart_ack_valid", O_valid, 0);
    I_ack = 1'b1;
    step();
    I_ack = 1'b0;
    checkOutput("idle_ack_valid", O_valid, 0);
    checkOutput("idle_ack_busy", O_busy, 0);

    // Reset while measuring aborts and clears everything
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    step();
    I_trigger = 1'b1;
    step();
    checkOutput("pre_reset_busy", O_busy, 1);
    reset_i   = 1'b1;
    I_trigger = 1'b0;
    step();
    reset_i = 1'b0;
    checkOutput("midrst_delay", O_delay, 0);
    checkOutput("midrst_width", O_width, 0);
    checkOutput("midrst_valid", O_valid, 0);
    checkOutput("midrst_busy", O_busy, 0);
    checkOutput("midrst_dovf", O_delay_ovf, 0);
    checkOutput("midrst_wovf", O_width_ovf, 0);
    tmp = '{0, 2, 2, 2, 2, 0, 0};
    applyStimulus("post_reset", tmp);

    // No edge after start: the delay counter saturates at 15
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
    end
    checkOutput("nosat_busy", O_busy, 1);
    checkOutput("nosat_valid", O_valid, 0);
    checkOutput("nosat_dovf", O_delay_ovf, 0);
    step();
`ifdef PW_TRIGMON_TIMEOUT_EN
    checkOutput("timeout_valid", O_valid, 1);
    checkOutput("timeout_busy", O_busy, 0);
    checkOutput("timeout_delay", O_delay, 15);
    checkOutput("timeout_dovf", O_delay_ovf, 1);
    checkOutput("timeout_width", O_width, 0);
`else
    checkOutput("sat_busy", O_busy, 1);
    checkOutput("sat_valid", O_valid, 0);
    checkOutput("sat_dovf", O_delay_ovf, 1);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    checkOutput("sat_still_busy", O_busy, 1);
    I_trigger = 1'b1;
    step();
    I_trigger = 1'b0;
    step();
    checkOutput("late_valid", O_valid, 1);
    checkOutput("late_delay", O_delay, 15);
    checkOutput("late_dovf", O_delay_ovf, 1);
    checkOutput("late_width", O_width, 1);
`endif
    I_ack = 1'b1;
    step();
    I_ack = 1'b0;
    checkOutput("sat_ack_valid", O_valid, 0);

    // A fresh start clears the overflow flag from the previous measurement
    tmp = '{0, 3, 1, 3, 1, 0, 0};
    applyStimulus("ovf_clear", tmp);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
